// File: rtl/servisia_sram_arb.sv
// servisia_sram_arb
// Two-port arbiter and strobe sequencer for the external 8-bit asynchronous
// SRAM. Port 0 is the CPU memory port and port 1 is the boot/debug loader.
// Each access is turned into an ordered CS_N/OE_N/WE_N/address/data sequence
// that is stretched by WAIT_STATES extra strobe cycles.
//
// Optional feature macro: SERVISIA_SRAM_ARB_RR_EN
//   defined   : round-robin arbitration. When both ports request, the port
//               that did not win last time wins. The last-winner register
//               resets to 1, so port 0 wins the first contention.
//   undefined : fixed priority. Port 0 always wins a contention and there is
//               no last-winner register.
//
// The SRAM strobes, address and data are all registered from the next FSM
// state, so they change only on clock edges and are clean for the chip.
// gnt_o is the one combinational output: it depends only on state and req_i.

module servisia_sram_arb #(
   parameter int ADDR_WIDTH  = 20,
   parameter int DATA_WIDTH  = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [1:0]              req_i,
   input  logic [1:0]              we_i,
   input  logic [2*ADDR_WIDTH-1:0] addr_i,
   input  logic [2*DATA_WIDTH-1:0] wdata_i,
   output logic [1:0]              gnt_o,
   output logic [1:0]              rsp_valid_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    sram_cs_no,
   output logic                    sram_oe_no,
   output logic                    sram_we_no,
   output logic [ADDR_WIDTH-1:0]   sram_addr_o,
   output logic [DATA_WIDTH-1:0]   sram_data_o,
   output logic                    sram_data_oe_o,
   input  logic [DATA_WIDTH-1:0]   sram_data_i
);

   // Wait counter reload value; only the low 4 bits are meaningful (0..15).
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD       = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_WR_HOLD  = 3'd4
   } state_t;

   state_t                  state_r;
   state_t                  next_s;
   logic [3:0]              cnt_r;
   logic                    cnt_done_s;

   logic                    win_s;
   logic                    winner_r;
   logic [1:0]              gnt_s;
   logic                    sel_we_s;
   logic [ADDR_WIDTH-1:0]   sel_addr_s;
   logic [DATA_WIDTH-1:0]   sel_wdata_s;

   logic                    cs_n_s;
   logic                    oe_n_s;
   logic                    we_n_s;
   logic                    data_oe_s;

   logic                    cs_n_r;
   logic                    oe_n_r;
   logic                    we_n_r;
   logic                    data_oe_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [DATA_WIDTH-1:0]   data_r;
   logic [1:0]              rsp_valid_r;
   logic [DATA_WIDTH-1:0]   rdata_r;

`ifdef SERVISIA_SRAM_ARB_RR_EN
   logic                    last_r;
`endif

   assign cnt_done_s = (cnt_r == 4'd0);

   // Arbitration: choose the winning port index from the current requests.
   always_comb begin
      win_s = 1'b0;
      if (req_i[0] && req_i[1]) begin
`ifdef SERVISIA_SRAM_ARB_RR_EN
         win_s = ~last_r;
`else
         win_s = 1'b0;
`endif
      end else if (req_i[1]) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   // Payload mux from the winning port and the combinational grant pulse.
   always_comb begin
      gnt_s       = 2'b00;
      sel_we_s    = win_s ? we_i[1] : we_i[0];
      sel_addr_s  = win_s ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0];
      sel_wdata_s = win_s ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0];
      if ((state_r == ST_IDLE) && (req_i != 2'b00)) begin
         gnt_s = win_s ? 2'b10 : 2'b01;
      end else begin
         gnt_s = 2'b00;
      end
   end

   assign gnt_o = gnt_s;

   // FSM next-state logic.
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_i != 2'b00) begin
               next_s = sel_we_s ? ST_WR_SETUP : ST_RD;
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_RD: begin
            if (cnt_done_s) begin
               next_s = ST_IDLE;
            end else begin
               next_s = ST_RD;
            end
         end
         ST_WR_SETUP: begin
            next_s = ST_WR_PULSE;
         end
         ST_WR_PULSE: begin
            if (cnt_done_s) begin
               next_s = ST_WR_HOLD;
            end else begin
               next_s = ST_WR_PULSE;
            end
         end
         ST_WR_HOLD: begin
            next_s = ST_IDLE;
         end
         default: begin
            next_s = ST_IDLE;
         end
      endcase
   end

   // Strobe levels for the state being entered; registered below so each
   // strobe is valid for the whole duration of its state.
   always_comb begin
      cs_n_s    = 1'b1;
      oe_n_s    = 1'b1;
      we_n_s    = 1'b1;
      data_oe_s = 1'b0;
      case (next_s)
         ST_IDLE: begin
            cs_n_s    = 1'b1;
            oe_n_s    = 1'b1;
            we_n_s    = 1'b1;
            data_oe_s = 1'b0;
         end
         ST_RD: begin
            cs_n_s    = 1'b0;
            oe_n_s    = 1'b0;
            we_n_s    = 1'b1;
            data_oe_s = 1'b0;
         end
         ST_WR_SETUP, ST_WR_HOLD: begin
            cs_n_s    = 1'b0;
            oe_n_s    = 1'b1;
            we_n_s    = 1'b1;
            data_oe_s = 1'b1;
         end
         ST_WR_PULSE: begin
            cs_n_s    = 1'b0;
            oe_n_s    = 1'b1;
            we_n_s    = 1'b0;
            data_oe_s = 1'b1;
         end
         default: begin
            cs_n_s    = 1'b1;
            oe_n_s    = 1'b1;
            we_n_s    = 1'b1;
            data_oe_s = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Wait counter: reloaded on entry to RD and WR_PULSE, counts down to 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_r <= 4'd0;
      end else if (((state_r == ST_IDLE) && (next_s == ST_RD)) || (state_r == ST_WR_SETUP)) begin
         cnt_r <= WAIT_LOAD;
      end else if (!cnt_done_s) begin
         cnt_r <= cnt_r - 4'd1;
      end
   end

   // Registered SRAM strobes; reset forces every strobe inactive at once.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cs_n_r    <= 1'b1;
         oe_n_r    <= 1'b1;
         we_n_r    <= 1'b1;
         data_oe_r <= 1'b0;
      end else begin
         cs_n_r    <= cs_n_s;
         oe_n_r    <= oe_n_s;
         we_n_r    <= we_n_s;
         data_oe_r <= data_oe_s;
      end
   end

   // Latch address, write data and winner index on the grant cycle; they
   // then stay put for the whole time chip select is low.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_r   <= '0;
         data_r   <= '0;
         winner_r <= 1'b0;
      end else if (gnt_s != 2'b00) begin
         addr_r   <= sel_addr_s;
         winner_r <= win_s;
         if (sel_we_s) begin
            data_r <= sel_wdata_s;
         end
      end
   end

`ifdef SERVISIA_SRAM_ARB_RR_EN
   // Remember which port won last so the other one wins the next contention.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_r <= 1'b1;
      end else if (gnt_s != 2'b00) begin
         last_r <= win_s;
      end
   end
`endif

   // One-cycle completion pulse: entering IDLE after a read, or entering
   // WR_HOLD after the write pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_r <= 2'b00;
      end else if (((state_r == ST_RD) || (state_r == ST_WR_PULSE)) && cnt_done_s) begin
         rsp_valid_r <= winner_r ? 2'b10 : 2'b01;
      end else begin
         rsp_valid_r <= 2'b00;
      end
   end

   // Capture chip read data on the final RD cycle; hold it otherwise.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_r <= '0;
      end else if ((state_r == ST_RD) && cnt_done_s) begin
         rdata_r <= sram_data_i;
      end
   end

   assign rsp_valid_o    = rsp_valid_r;
   assign rdata_o        = rdata_r;
   assign sram_cs_no     = cs_n_r;
   assign sram_oe_no     = oe_n_r;
   assign sram_we_no     = we_n_r;
   assign sram_addr_o    = addr_r;
   assign sram_data_o    = data_r;
   assign sram_data_oe_o = data_oe_r;

endmodule

// File: tb/tb_servisia_sram_arb.sv
// Testbench for servisia_sram_arb: directed and random accesses against a
// byte-array chip model and a reference memory, plus protocol invariants.
module tb_servisia_sram_arb;

   localparam int AW = 20;
   localparam int DW = 8;
   localparam int W  = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    req = 2'b00;
   logic [1:0]    we = 2'b00;
   logic [2*AW-1:0] addr = '0;
   logic [2*DW-1:0] wdata = '0;
   logic [1:0]    gnt, rsp_valid;
   logic [DW-1:0] rdata;
   logic          cs_n, oe_n, we_n, sdata_oe;
   logic [AW-1:0] saddr;
   logic [DW-1:0] sdata_o, sdata_i;

   // second instance with the maximum wait-state count
   logic [1:0]    req15 = 2'b00;
   logic [2*AW-1:0] addr15 = '0;
   logic [1:0]    gnt15, rsp15;
   logic [DW-1:0] rdata15;
   logic          cs_n15, oe_n15, we_n15, sdata_oe15;
   logic [AW-1:0] saddr15;
   logic [DW-1:0] sdata_o15, sdata_i15;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0]  chip_mem [0:(1<<AW)-1];
   logic [7:0]  ref_mem [logic [19:0]];
   logic [19:0] pool [8];
   logic [7:0]  last_rd = 8'h00;
   int          last_win = 1;
   bit          last_valid = 1'b0;
   int          last_gnt_cyc = 0;
   bit          last_w = 1'b0;

   servisia_sram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(W)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rdata_o(rdata),
      .sram_cs_no(cs_n), .sram_oe_no(oe_n), .sram_we_no(we_n),
      .sram_addr_o(saddr), .sram_data_o(sdata_o), .sram_data_oe_o(sdata_oe),
      .sram_data_i(sdata_i));

   servisia_sram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(15)) dut15 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req15), .we_i(2'b00), .addr_i(addr15),
      .wdata_i(16'h0000), .gnt_o(gnt15), .rsp_valid_o(rsp15), .rdata_o(rdata15),
      .sram_cs_no(cs_n15), .sram_oe_no(oe_n15), .sram_we_no(we_n15),
      .sram_addr_o(saddr15), .sram_data_o(sdata_o15), .sram_data_oe_o(sdata_oe15),
      .sram_data_i(sdata_i15));

   always #5 clk = ~clk;

   // cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // chip models: read is combinational while selected with OE low
   assign sdata_i   = (!cs_n && !oe_n) ? chip_mem[saddr] : 8'h00;
   assign sdata_i15 = (!cs_n15 && !oe_n15) ? (saddr15[7:0] ^ 8'hC3) : 8'h00;

   // chip write: captured on a clock edge while selected with WE low
   always @(posedge clk) begin
      if (!cs_n && !we_n && sdata_oe) chip_mem[saddr] <= sdata_o;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_read(input logic [19:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   // protocol invariants, sampled mid-cycle
   logic          prev_cs_n = 1'b1;
   logic          prev_doe = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_data = '0;
   always @(negedge clk) begin
      if (rst_n) begin
         chk("inv_oe_we", {31'd0, !oe_n && !we_n}, 32'd0);
         chk("inv_oe_doe", {31'd0, !oe_n && sdata_oe}, 32'd0);
         if (!cs_n && !prev_cs_n) chk("inv_addr_stable", saddr, prev_addr);
         if (sdata_oe && prev_doe) chk("inv_data_stable", sdata_o, prev_data);
      end
      prev_cs_n = cs_n;
      prev_doe  = sdata_oe;
      prev_addr = saddr;
      prev_data = sdata_o;
   end

   // One complete access on the main instance; called and returns just after a negedge.
   task automatic access(input int p, input bit w, input logic [19:0] a, input logic [7:0] d);
      logic [1:0] oh;
      bit         got;
      int         gc;
      int         len;
      logic [7:0] exp_rd;
      oh = (p == 1) ? 2'b10 : 2'b01;
      req[p] = 1'b1;
      we[p]  = w;
      if (p == 1) begin addr[2*AW-1:AW] = a; wdata[2*DW-1:DW] = d; end
      else        begin addr[AW-1:0]    = a; wdata[DW-1:0]    = d; end
      got = 1'b0;
      gc  = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         #1;
         if (gnt == oh) begin got = 1'b1; gc = cyc; end
         else @(negedge clk);
      end
      chk("grant_seen", {31'd0, got}, 32'd1);
      if (!got) begin req[p] = 1'b0; return; end
      if (last_valid) chk("gnt_gap", gc - last_gnt_cyc, last_w ? W + 4 : W + 2);
      last_valid = 1'b1; last_gnt_cyc = gc; last_w = w; last_win = p;
      @(posedge clk); #1;
      req[p] = 1'b0;
      we[p]  = $urandom_range(0, 1);
      addr   = {$urandom, $urandom};
      wdata  = $urandom;
      exp_rd = ref_read(a);
      len = w ? W + 3 : W + 2;
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         if (k < len) begin
            chk("rsp_idle", rsp_valid, 2'b00);
            chk("rdata_hold", rdata, last_rd);
         end
         if (!w) begin
            if (k < len) begin
               chk("rd_cs", cs_n, 1'b0); chk("rd_oe", oe_n, 1'b0);
               chk("rd_we", we_n, 1'b1); chk("rd_doe", sdata_oe, 1'b0);
               chk("rd_addr", saddr, a);
            end else begin
               chk("rd_rsp", rsp_valid, oh);
               chk("rd_data", rdata, exp_rd);
               chk("rd_cs_end", cs_n, 1'b1);
            end
         end else begin
            chk("wr_cs", cs_n, 1'b0); chk("wr_oe", oe_n, 1'b1);
            chk("wr_doe", sdata_oe, 1'b1); chk("wr_addr", saddr, a);
            chk("wr_data", sdata_o, d);
            chk("wr_we", we_n, (k == 1 || k == len) ? 1'b1 : 1'b0);
            if (k == len) begin
               chk("wr_rsp", rsp_valid, oh);
               chk("wr_rdata_hold", rdata, last_rd);
            end
         end
      end
      if (w) ref_mem[a] = d;
      else   last_rd = exp_rd;
   endtask

   initial begin
      logic [1:0]  exp_oh, prev_oh;
      int          exp_p, prev_p, nget, prev_gc, low_cnt, rsp_k;
      logic [1:0]  rsp_seen;
      logic [7:0]  rd15;
      logic [19:0] ca [2];
      bit          got;

      pool[0] = 20'h00010; pool[1] = 20'hFFFFF; pool[2] = 20'h00000; pool[3] = 20'h12345;
      pool[4] = 20'h0ABCE; pool[5] = 20'h80001; pool[6] = 20'h7FFFE; pool[7] = 20'h00FF0;
      for (int i = 0; i < 8; i++) begin
         chip_mem[pool[i]] = pool[i][7:0] ^ 8'h5A;
         ref_mem[pool[i]]  = pool[i][7:0] ^ 8'h5A;
      end
      chip_mem[20'h00010] = 8'hA5;
      ref_mem[20'h00010]  = 8'hA5;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_cs", cs_n, 1'b1); chk("rst_oe", oe_n, 1'b1); chk("rst_we", we_n, 1'b1);
      chk("rst_doe", sdata_oe, 1'b0); chk("rst_addr", saddr, 20'h0);
      chk("rst_data", sdata_o, 8'h00); chk("rst_gnt", gnt, 2'b00);
      chk("rst_rsp", rsp_valid, 2'b00); chk("rst_rdata", rdata, 8'h00);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_gnt", gnt, 2'b00);

      // directed: read 0x10 -> A5, write FFFFF=3C, write then read 0x77
      access(0, 1'b0, 20'h00010, 8'h00);
      access(1, 1'b1, 20'hFFFFF, 8'h3C);
      chk("chip_ffff", chip_mem[20'hFFFFF], 8'h3C);
      access(0, 1'b1, 20'h12345, 8'h77);
      access(0, 1'b0, 20'h12345, 8'h00);
      access(1, 1'b0, 20'hFFFFF, 8'h00);

      // contention: both ports read continuously
      ca[0] = pool[0]; ca[1] = pool[3];
      req = 2'b11; we = 2'b00; addr = {ca[1], ca[0]};
      nget = 0; prev_gc = 0; prev_oh = 2'b00; prev_p = 0;
      for (int i = 0; i < 60 && nget < 4; i++) begin
         #1;
         if (gnt != 2'b00) begin
`ifdef SERVISIA_SRAM_ARB_RR_EN
            exp_p = 1 - last_win;
`else
            exp_p = 0;
`endif
            exp_oh = (exp_p == 1) ? 2'b10 : 2'b01;
            chk("cont_gnt", gnt, exp_oh);
            if (nget > 0) begin
               chk("cont_gap", cyc - prev_gc, W + 2);
               chk("cont_rsp", rsp_valid, prev_oh);
               chk("cont_rdata", rdata, ref_read(ca[prev_p]));
               last_rd = ref_read(ca[prev_p]);
            end
            last_win = exp_p; prev_p = exp_p; prev_oh = exp_oh; prev_gc = cyc;
            nget++;
         end
         @(negedge clk);
      end
      chk("cont_count", nget, 4);
      req = 2'b00;
      repeat (W + 1) @(negedge clk);
      chk("cont_last_rsp", rsp_valid, prev_oh);
      chk("cont_last_rdata", rdata, ref_read(ca[prev_p]));
      last_rd = ref_read(ca[prev_p]);
      last_valid = 1'b0;

      // random traffic against the reference memory
      for (int n = 0; n < 40; n++) begin
         access($urandom_range(0, 1), 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 8'($urandom));
      end

      // reset during the write pulse
      req[0] = 1'b1; we[0] = 1'b1; addr[AW-1:0] = 20'h0ABCD; wdata[DW-1:0] = 8'h99;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         #1;
         if (gnt == 2'b01) got = 1'b1; else @(negedge clk);
      end
      chk("rstw_gnt", {31'd0, got}, 32'd1);
      @(posedge clk); #1; req = 2'b00;
      @(negedge clk);
      @(negedge clk);
      chk("rstw_pulse", we_n, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rstw_we", we_n, 1'b1); chk("rstw_cs", cs_n, 1'b1); chk("rstw_oe", oe_n, 1'b1);
      chk("rstw_doe", sdata_oe, 1'b0); chk("rstw_rsp", rsp_valid, 2'b00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rstw_rsp_hold", rsp_valid, 2'b00);
      end
      rst_n = 1'b1;
      last_win = 1; last_rd = 8'h00; last_valid = 1'b0;
      @(negedge clk);
      chk("rstw_after_rsp", rsp_valid, 2'b00);
      chk("rstw_rdata", rdata, 8'h00);
      access(1, 1'b0, 20'h00010, 8'h00);
      access(0, 1'b1, 20'h00000, 8'h5E);
      access(1, 1'b0, 20'h00000, 8'h00);

      // 15 wait states on the second instance
      req15 = 2'b01; addr15 = {20'h0, 20'h12345};
      #1;
      chk("w15_gnt", gnt15, 2'b01);
      @(posedge clk); #1; req15 = 2'b00;
      low_cnt = 0; rsp_k = 0; rsp_seen = 2'b00; rd15 = 8'h00;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (!cs_n15 && !oe_n15) low_cnt++;
         if (rsp15 != 2'b00 && rsp_k == 0) begin rsp_k = k; rsp_seen = rsp15; rd15 = rdata15; end
      end
      chk("w15_low", low_cnt, 16);
      chk("w15_rsp_at", rsp_k, 17);
      chk("w15_rsp", rsp_seen, 2'b01);
      chk("w15_rdata", rd15, 8'h45 ^ 8'hC3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
